load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, one-cycle chip-select memory access, held response.
// Optional build macro LSU_MISALIGN_ERR_EN turns misaligned halfword/word accesses into error responses.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       write_data,
    output logic [3:0]        mask,
    output logic              rd_en,
    output logic              wr_en,
    output logic              cs,
    input  logic [31:0]       read_data,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic        req_fire;
    logic        req_illegal;
    logic        req_misalign;
    logic        req_err;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata_rep;

    // Handshake: a request transfers on a posedge with req_valid & req_ready,
    // a response on a posedge with rsp_valid & rsp_ready; both sides hold stable while waiting.
    assign req_fire = req_valid && req_ready;

    // Mask encoding is the memory's lane/extension code, not a byte-enable.
    always_comb begin
        req_mask      = 4'b0000;
        req_wdata_rep = 32'h0;
        req_illegal   = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000: begin req_mask = 4'b0000; req_wdata_rep = {4{req_wdata[7:0]}};  end
                3'b001: begin req_mask = 4'b0001; req_wdata_rep = {2{req_wdata[15:0]}}; end
                3'b010: begin req_mask = 4'b1000; req_wdata_rep = req_wdata;            end
                default: req_illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000: req_mask = 4'b0000;
                3'b001: req_mask = 4'b0001;
                3'b010: req_mask = 4'b1000;
                3'b100: req_mask = 4'b0010;
                3'b101: req_mask = 4'b0100;
                default: req_illegal = 1'b1;
            endcase
        end
    end

`ifdef LSU_MISALIGN_ERR_EN
    assign req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    assign req_err = req_illegal || req_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = req_err ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr       <= '0;
            write_data <= 32'h0;
            mask       <= 4'b0000;
            we_q       <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            if (req_fire) begin
                addr       <= req_addr;
                mask       <= req_mask;
                write_data <= req_wdata_rep;
                we_q       <= req_we;
                if (req_err) begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b1;
                end
            end
            // Memory already extracted and extended the load data; pass it through untouched.
            if (state == ACCESS) begin
                rsp_rdata <= we_q ? 32'h0 : read_data;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Strobes decode straight from state so reset forces them inactive without waiting for a clock.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign cs        = (state != ACCESS);
    assign wr_en     = !((state == ACCESS) && we_q);
    assign rd_en     = (state == ACCESS) && !we_q;
    assign state_dbg = state;

endmodule
